// File: rtl/ccff_mon_pkg.sv
// Shared types and CRC-16 helper for the configuration-chain readback monitor.
package ccff_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  localparam logic [15:0] CRC16_POLY_DEFAULT = 16'h1021;
  localparam logic [15:0] CRC16_INIT_DEFAULT = 16'hFFFF;

  // One serial CRC-16 step, MSB-first, x^16 term implicit in poly.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din,
                                             input logic [15:0] poly);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_readback_monitor_if.sv
// Chain-tail / golden-signature / verdict bundle of the readback monitor.
interface ccff_readback_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start_i;
  logic             shift_en_i;
  logic             ccff_tail_i;
  logic             sig_shift_i;
  logic             sig_tdi_i;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic             fail_o;
  logic [CNT_W-1:0] bit_cnt_o;
  logic [15:0]      crc_o;

  modport master (
    output start_i, shift_en_i, ccff_tail_i, sig_shift_i, sig_tdi_i,
    input  busy_o, done_o, pass_o, fail_o, bit_cnt_o, crc_o
  );

  modport slave (
    input  start_i, shift_en_i, ccff_tail_i, sig_shift_i, sig_tdi_i,
    output busy_o, done_o, pass_o, fail_o, bit_cnt_o, crc_o
  );
endinterface

// File: rtl/crc16_serial.sv
// Serial CRC-16 register: init has priority over en, one bit per enabled cycle.
module crc16_serial
  import ccff_mon_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY_DEFAULT,
  parameter logic [15:0] INIT = CRC16_INIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        din_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = INIT;
    end else if (en_i) begin
      crc_d = crc16_step(crc_q, din_i, POLY);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_readback_monitor.sv
// Folds the config-chain tail into a CRC-16 and compares it with a JTAG-loaded golden signature.
// Optional CCFF_MON_OVERRUN_EN: shifts seen in CHECK/DONE poison the next verdict.
module ccff_readback_monitor
  import ccff_mon_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] CRC_POLY  = CRC16_POLY_DEFAULT,
  parameter logic [15:0] CRC_INIT  = CRC16_INIT_DEFAULT
) (
  input logic                    tck_i,
  input logic                    rst_ni,
  ccff_readback_monitor_if.slave bus
);

  mon_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [15:0]      golden_d, golden_q;
  logic             pass_d, pass_q;
  logic             fail_d, fail_q;
  logic [15:0]      crc;
  logic             crc_init;
  logic             crc_en;
  logic             ovr_hit;

  crc16_serial #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc (
    .clk_i  (tck_i),
    .rst_ni (rst_ni),
    .init_i (crc_init),
    .en_i   (crc_en),
    .din_i  (bus.ccff_tail_i),
    .crc_o  (crc)
  );

`ifdef CCFF_MON_OVERRUN_EN
  logic ovr_d, ovr_q;

  always_comb begin
    ovr_d = ovr_q;
    if (bus.start_i) begin
      ovr_d = 1'b0;
    end else if (bus.shift_en_i && (state_q == ST_CHECK || state_q == ST_DONE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge tck_i) begin
    if (!rst_ni) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  // A shift landing in the CHECK cycle itself must already spoil that verdict.
  assign ovr_hit = ovr_q | (bus.shift_en_i && state_q == ST_CHECK);
`else
  assign ovr_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    golden_d = golden_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    // start outranks every state, so an abort in RUN/CHECK is just a fresh start
    if (bus.start_i) begin
      state_d  = ST_RUN;
      crc_init = 1'b1;
      cnt_d    = '0;
      pass_d   = 1'b0;
      fail_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.sig_shift_i) begin
            golden_d = {golden_q[14:0], bus.sig_tdi_i};
          end
        end
        ST_RUN: begin
          if (bus.shift_en_i) begin
            crc_en = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(CHAIN_LEN)) begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          pass_d  = (crc == golden_q) && !ovr_hit;
          fail_d  = !pass_d;
          state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      golden_q <= golden_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  assign bus.busy_o    = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign bus.done_o    = (state_q == ST_DONE);
  assign bus.pass_o    = pass_q;
  assign bus.fail_o    = fail_q;
  assign bus.bit_cnt_o = cnt_q;
  assign bus.crc_o     = crc;

endmodule

// File: tb/tb_ccff_readback_monitor.sv
// Bench for ccff_readback_monitor: an 8-bit and a 72-bit chain instance checked against a long-division CRC model.
module tb_ccff_readback_monitor;

  logic tck = 1'b0;
  always #5 tck = ~tck;

  logic rst_n, start8, start72, shift_en, tail, sig_shift, tdi;
  int unsigned vectors = 0;
  int unsigned errors  = 0;

  ccff_readback_monitor_if #(.CNT_W(16)) if8 ();
  ccff_readback_monitor_if #(.CNT_W(16)) if72 ();

  assign if8.start_i      = start8;
  assign if8.shift_en_i   = shift_en;
  assign if8.ccff_tail_i  = tail;
  assign if8.sig_shift_i  = sig_shift;
  assign if8.sig_tdi_i    = tdi;
  assign if72.start_i     = start72;
  assign if72.shift_en_i  = shift_en;
  assign if72.ccff_tail_i = tail;
  assign if72.sig_shift_i = sig_shift;
  assign if72.sig_tdi_i   = tdi;

  ccff_readback_monitor #(
    .CHAIN_LEN (8), .CNT_W (16), .CRC_POLY (16'h1021), .CRC_INIT (16'hFFFF)
  ) dut8 (.tck_i(tck), .rst_ni(rst_n), .bus(if8));

  ccff_readback_monitor #(
    .CHAIN_LEN (72), .CNT_W (16), .CRC_POLY (16'h1021), .CRC_INIT (16'hFFFF)
  ) dut72 (.tck_i(tck), .rst_ni(rst_n), .bus(if72));

  // CRC as the remainder of (INIT*x^n + M*x^16) mod G, G = x^16 + 0x1021.
  function automatic logic [15:0] ref_crc(input logic [71:0] data, input int n);
    logic [95:0] v;
    logic [95:0] g;
    v = (96'(16'hFFFF) << n) ^ (96'(data) << 16);
    g = 96'(17'h11021);
    for (int k = n + 15; k >= 16; k--) begin
      if (v[k]) v = v ^ (g << (k - 16));
    end
    return v[15:0];
  endfunction

  task automatic cyc();
    @(negedge tck);
  endtask

  task automatic idle_inputs();
    start8 = 1'b0; start72 = 1'b0; shift_en = 1'b0;
    tail = 1'b0; sig_shift = 1'b0; tdi = 1'b0;
  endtask

  task automatic load_golden(input logic [15:0] g);
    for (int i = 15; i >= 0; i--) begin
      sig_shift = 1'b1; tdi = g[i]; cyc();
    end
    sig_shift = 1'b0; tdi = 1'b0;
  endtask

  // Start the chosen instance, shift n bits MSB-first, wait (bounded) for done.
  task automatic run_bits(input logic [71:0] data, input int n, input bit gaps, input bit noise);
    int unsigned g;
    logic d;
    if (n == 8) start8 = 1'b1; else start72 = 1'b1;
    if (noise) begin sig_shift = 1'b1; tdi = 1'b1; end
    cyc();
    start8 = 1'b0; start72 = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      g = gaps ? $urandom_range(0, 3) : 0;
      repeat (g) begin
        shift_en = 1'b0;
        if (noise) begin sig_shift = 1'b1; tdi = 1'($urandom_range(0, 1)); end
        cyc();
      end
      shift_en = 1'b1; tail = data[i];
      if (noise) begin sig_shift = 1'b1; tdi = 1'($urandom_range(0, 1)); end
      cyc();
    end
    shift_en = 1'b0; sig_shift = 1'b0; tail = 1'b0; tdi = 1'b0;
    d = (n == 8) ? if8.done_o : if72.done_o;
    for (int k = 0; k < 4 && !d; k++) begin
      cyc();
      d = (n == 8) ? if8.done_o : if72.done_o;
    end
    vectors++;
    if (d !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout n=%0d: done=%b, expected 1", n, d);
    end
  endtask

  task automatic test_reset();
    idle_inputs(); rst_n = 1'b0; cyc(); cyc();
    vectors++;
    if ({if8.busy_o, if8.done_o, if8.pass_o, if8.fail_o, if8.bit_cnt_o, if8.crc_o} !== {4'b0000, 16'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset_dut8: got %b/%0d/%h, expected 0000/0/ffff",
               {if8.busy_o, if8.done_o, if8.pass_o, if8.fail_o}, if8.bit_cnt_o, if8.crc_o);
    end
    vectors++;
    if ({if72.busy_o, if72.done_o, if72.pass_o, if72.fail_o, if72.bit_cnt_o, if72.crc_o} !== {4'b0000, 16'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset_dut72: got %b/%0d/%h, expected 0000/0/ffff",
               {if72.busy_o, if72.done_o, if72.pass_o, if72.fail_o}, if72.bit_cnt_o, if72.crc_o);
    end
    rst_n = 1'b1;
    shift_en = 1'b1; tail = 1'b1; cyc(); shift_en = 1'b0; tail = 1'b0;
    vectors++;
    if (if8.bit_cnt_o !== 16'd0 || if8.crc_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL idle_shift_ignored: got cnt=%0d crc=%h, expected 0/ffff", if8.bit_cnt_o, if8.crc_o);
    end
    load_golden(16'hE1F0);
    start8 = 1'b1; cyc(); start8 = 1'b0;
    vectors++;
    if ({if8.busy_o, if8.done_o, if8.bit_cnt_o, if8.crc_o} !== {2'b10, 16'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL busy_after_start: got busy=%b done=%b cnt=%0d crc=%h, expected 1/0/0/ffff",
               if8.busy_o, if8.done_o, if8.bit_cnt_o, if8.crc_o);
    end
    for (int i = 0; i < 8; i++) begin shift_en = 1'b1; tail = 1'b0; cyc(); end
    shift_en = 1'b0;
    vectors++;
    if ({if8.busy_o, if8.done_o, if8.pass_o, if8.fail_o, if8.bit_cnt_o, if8.crc_o} !== {4'b1000, 16'd8, 16'hE1F0}) begin
      errors++;
      $display("FAIL check_cycle: got %b/%0d/%h, expected 1000/8/e1f0",
               {if8.busy_o, if8.done_o, if8.pass_o, if8.fail_o}, if8.bit_cnt_o, if8.crc_o);
    end
    cyc();
    vectors++;
    if ({if8.busy_o, if8.done_o, if8.pass_o, if8.fail_o, if8.bit_cnt_o, if8.crc_o} !== {4'b0110, 16'd8, 16'hE1F0}) begin
      errors++;
      $display("FAIL zero_byte_pass: got %b/%0d/%h, expected 0110/8/e1f0",
               {if8.busy_o, if8.done_o, if8.pass_o, if8.fail_o}, if8.bit_cnt_o, if8.crc_o);
    end
  endtask

  task automatic test_crc_vector();
    logic [71:0] msg;
    logic [71:0] bad;
    logic [15:0] exp_bad;
    msg = "123456789";
    load_golden(16'h29B1);
    run_bits(msg, 72, 1'b1, 1'b1);
    vectors++;
    if ({if72.pass_o, if72.fail_o, if72.bit_cnt_o, if72.crc_o} !== {2'b10, 16'd72, 16'h29B1}) begin
      errors++;
      $display("FAIL ascii_check_pass: got pf=%b cnt=%0d crc=%h, expected 10/72/29b1",
               {if72.pass_o, if72.fail_o}, if72.bit_cnt_o, if72.crc_o);
    end
    bad = msg ^ (72'd1 << $urandom_range(0, 71));
    exp_bad = ref_crc(bad, 72);
    load_golden(16'h29B1);
    run_bits(bad, 72, 1'b1, 1'b0);
    vectors++;
    if ({if72.pass_o, if72.fail_o, if72.crc_o} !== {2'b01, exp_bad}) begin
      errors++;
      $display("FAIL ascii_bitflip_fail: got pf=%b crc=%h, expected 01/%h",
               {if72.pass_o, if72.fail_o}, if72.crc_o, exp_bad);
    end
  endtask

  task automatic test_zero_golden();
    load_golden(16'h0000);
    run_bits(72'd0, 8, 1'b0, 1'b0);
    vectors++;
    if ({if8.done_o, if8.pass_o, if8.fail_o, if8.crc_o} !== {3'b101, 16'hE1F0}) begin
      errors++;
      $display("FAIL zero_golden_fail: got dpf=%b crc=%h, expected 101/e1f0",
               {if8.done_o, if8.pass_o, if8.fail_o}, if8.crc_o);
    end
  endtask

  task automatic test_restart();
    load_golden(16'hE1F0);
    start8 = 1'b1; cyc(); start8 = 1'b0;
    for (int i = 0; i < 5; i++) begin shift_en = 1'b1; tail = 1'($urandom_range(0, 1)); cyc(); end
    shift_en = 1'b0; tail = 1'b0;
    vectors++;
    if (if8.bit_cnt_o !== 16'd5) begin
      errors++;
      $display("FAIL partial_count: got %0d, expected 5", if8.bit_cnt_o);
    end
    start8 = 1'b1; cyc(); start8 = 1'b0;
    vectors++;
    if ({if8.busy_o, if8.bit_cnt_o, if8.crc_o} !== {1'b1, 16'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL restart_reinit: got busy=%b cnt=%0d crc=%h, expected 1/0/ffff",
               if8.busy_o, if8.bit_cnt_o, if8.crc_o);
    end
    for (int i = 0; i < 8; i++) begin shift_en = 1'b1; tail = 1'b0; cyc(); end
    shift_en = 1'b0;
    cyc();
    vectors++;
    if ({if8.done_o, if8.pass_o, if8.fail_o, if8.bit_cnt_o, if8.crc_o} !== {3'b110, 16'd8, 16'hE1F0}) begin
      errors++;
      $display("FAIL restart_pass: got dpf=%b cnt=%0d crc=%h, expected 110/8/e1f0",
               {if8.done_o, if8.pass_o, if8.fail_o}, if8.bit_cnt_o, if8.crc_o);
    end
  endtask

  task automatic test_reset_midrun();
    logic [55:0] body;
    logic [71:0] framed;
    logic [7:0]  d;
    logic [15:0] exp;
    load_golden(16'hFFFF);
    body   = {24'($urandom), 32'($urandom)};
    framed = {body, ref_crc(72'(body), 56)};
    start72 = 1'b1; cyc(); start72 = 1'b0;
    for (int i = 0; i < 20; i++) begin shift_en = 1'b1; tail = 1'($urandom_range(0, 1)); cyc(); end
    shift_en = 1'b0; tail = 1'b0;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    vectors++;
    if ({if72.busy_o, if72.done_o, if72.pass_o, if72.fail_o, if72.bit_cnt_o, if72.crc_o} !== {4'b0000, 16'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL midrun_reset: got %b/%0d/%h, expected 0000/0/ffff",
               {if72.busy_o, if72.done_o, if72.pass_o, if72.fail_o}, if72.bit_cnt_o, if72.crc_o);
    end
    // Message followed by its own CRC leaves a zero residue: passes only if golden was cleared.
    exp = ref_crc(framed, 72);
    run_bits(framed, 72, 1'b1, 1'b0);
    vectors++;
    if ({if72.pass_o, if72.fail_o, if72.crc_o} !== {2'b10, exp}) begin
      errors++;
      $display("FAIL golden_cleared: got pf=%b crc=%h, expected 10/%h", {if72.pass_o, if72.fail_o}, if72.crc_o, exp);
    end
    d = 8'($urandom);
    exp = ref_crc(72'(d), 8);
    load_golden(exp);
    run_bits(72'(d), 8, 1'b0, 1'b0);
    vectors++;
    if ({if8.pass_o, if8.fail_o, if8.crc_o} !== {2'b10, exp}) begin
      errors++;
      $display("FAIL golden_reload: got pf=%b crc=%h, expected 10/%h", {if8.pass_o, if8.fail_o}, if8.crc_o, exp);
    end
  endtask

  task automatic test_random();
    logic [7:0]  d;
    logic [15:0] exp, g;
    bit          good;
    for (int it = 0; it < 8; it++) begin
      d    = 8'($urandom);
      good = 1'($urandom_range(0, 1));
      exp  = ref_crc(72'(d), 8);
      g    = good ? exp : exp ^ 16'($urandom_range(1, 65535));
      load_golden(g);
      run_bits(72'(d), 8, 1'b1, 1'b1);
      vectors++;
      if ({if8.busy_o, if8.pass_o, if8.fail_o, if8.bit_cnt_o, if8.crc_o} !== {1'b0, good, !good, 16'd8, exp}) begin
        errors++;
        $display("FAIL random_%0d: got bpf=%b cnt=%0d crc=%h, expected %b/8/%h", it,
                 {if8.busy_o, if8.pass_o, if8.fail_o}, if8.bit_cnt_o, if8.crc_o, {1'b0, good, !good}, exp);
      end
    end
  endtask

`ifdef CCFF_MON_OVERRUN_EN
  task automatic test_overrun();
    load_golden(16'hE1F0);
    run_bits(72'd0, 8, 1'b0, 1'b0);
    shift_en = 1'b1; cyc(); shift_en = 1'b0;
    vectors++;
    if ({if8.done_o, if8.pass_o, if8.fail_o, if8.bit_cnt_o} !== {3'b110, 16'd8}) begin
      errors++;
      $display("FAIL overrun_done_hold: got dpf=%b cnt=%0d, expected 110/8", {if8.done_o, if8.pass_o, if8.fail_o}, if8.bit_cnt_o);
    end
    run_bits(72'd0, 8, 1'b0, 1'b0);
    vectors++;
    if ({if8.pass_o, if8.fail_o} !== 2'b10) begin
      errors++;
      $display("FAIL overrun_cleared_by_start: got pf=%b, expected 10", {if8.pass_o, if8.fail_o});
    end
    start8 = 1'b1; cyc(); start8 = 1'b0;
    for (int i = 0; i < 9; i++) begin shift_en = 1'b1; tail = 1'b0; cyc(); end
    shift_en = 1'b0;
    vectors++;
    if ({if8.done_o, if8.pass_o, if8.fail_o, if8.bit_cnt_o, if8.crc_o} !== {3'b101, 16'd8, 16'hE1F0}) begin
      errors++;
      $display("FAIL overrun_in_check: got dpf=%b cnt=%0d crc=%h, expected 101/8/e1f0",
               {if8.done_o, if8.pass_o, if8.fail_o}, if8.bit_cnt_o, if8.crc_o);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    test_reset();
    test_crc_vector();
    test_zero_golden();
    test_restart();
    test_reset_midrun();
    test_random();
`ifdef CCFF_MON_OVERRUN_EN
    test_overrun();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ccff_readback_monitor.md
# ccff_readback_monitor

Downstream checker on the configuration-chain tail: samples the bit stream leaving the fabric configuration flip-flop chain on every programming-clock qualifier and folds it into a CRC-16. It compares the result against a golden signature shifted in over JTAG and reports pass/fail. It sits between the chain tail (`tdo_core_o`) and the PMU/TAP readback path, and gives the secured-bitstream flow a hardware integrity verdict without streaming the whole chain off-chip.

## Interface
- `CHAIN_LEN`, 1024: number of chain bits per readback; valid range 1..65535.
- `CNT_W`, 16: width of the bit counter; must satisfy `2**CNT_W > CHAIN_LEN`.
- `CRC_POLY`, 16'h1021: CRC-16 generator polynomial; the x^16 term is implicit.
- `CRC_INIT`, 16'hFFFF: CRC register value loaded on `start_i`.
- `tck_i` in 1: the only clock; all state updates on its rising edge.
- `rst_ni` in 1: reset is synchronous and active-low.
- `start_i` in 1: single-cycle pulse that starts a readback run.
- `shift_en_i` in 1: progclk qualifier, one `tck_i` cycle per chain shift.
- `ccff_tail_i` in 1: chain tail bit, valid when `shift_en_i`=1.
- `sig_shift_i` in 1: shifts `sig_tdi_i` into the golden register, MSB first.
- `sig_tdi_i` in 1: golden signature serial data.
- `busy_o` out 1: high while in RUN or CHECK.
- `done_o` out 1: high in DONE.
- `pass_o` out 1: verdict valid when `done_o`=1.
- `fail_o` out 1: verdict valid when `done_o`=1.
- `bit_cnt_o` out CNT_W: number of bits absorbed in the current or last run.
- `crc_o` out 16: current CRC register value.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE
  - `sig_shift_i`=1: `golden <= {golden[14:0], sig_tdi_i}`.
  - `start_i`=1: go to RUN, `crc <= CRC_INIT`, `cnt <= 0`, clear `pass_o` and `fail_o`.
- RUN
  - Each `shift_en_i`=1: `fb = crc[15] ^ ccff_tail_i`; `crc <= {crc[14:0],1'b0} ^ (fb ? CRC_POLY : 0)`; `cnt <= cnt+1`.
  - When the update makes `cnt == CHAIN_LEN`, go to CHECK.
- CHECK (one cycle): `pass_o <= (crc == golden)`, `fail_o <= ~(crc == golden)`, then go to DONE.
- DONE: outputs hold. `start_i` starts a new run (same actions as from IDLE). `sig_shift_i` is accepted as in IDLE.
- `start_i` during RUN or CHECK aborts the current run and restarts it: CRC and count are re-initialised and the FSM stays in or returns to RUN.
- `sig_shift_i` in RUN or CHECK is ignored; the golden register is frozen.
- Same-cycle `start_i` and `sig_shift_i` in IDLE or DONE: start wins, the shift is dropped.
- `shift_en_i` outside RUN is ignored; the counter does not move.
- `pass_o` and `fail_o` are mutually exclusive and both 0 except in DONE.

## Timing
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `pass_o`=0, `fail_o`=0, `bit_cnt_o`=0, `crc_o`=CRC_INIT, `golden`=0.
- Reset asserted mid-run forces IDLE on the next edge; the partial CRC is discarded and the golden register is cleared.
- `busy_o` rises the cycle after `start_i`.
- With back-to-back shifts, the last bit is absorbed at edge N, CHECK is entered at edge N, and `done_o` plus the verdict are valid at edge N+1 (one cycle after the last bit).
- `shift_en_i` may have arbitrary gaps; the CRC only advances on qualified cycles.

## Configuration
- `CCFF_MON_OVERRUN_EN`
  - Defined: a `shift_en_i` arriving in CHECK, or in DONE before a new `start_i`, sets an overrun flag. The next verdict forces `fail_o`=1 and `pass_o`=0. The flag clears on `start_i`.
  - Undefined: such extra shifts are ignored with no effect on the verdict.

## Structure
- Shared package `ccff_mon_pkg` holds:
  - the FSM state enum (2-bit);
  - the default `CRC_POLY` and `CRC_INIT` constants;
  - a `crc16_step(crc, bit, poly)` function.
- One sub-module, `crc16_serial`: the CRC register with `init` and `en` inputs, instantiated once. The FSM, counter and golden shift register stay in the top.

## Test plan
- Reset: `CRC_INIT`=16'hFFFF, shift golden 16'hE1F0, `CHAIN_LEN`=8, start, 8 zero bits back-to-back -> `crc_o`=16'hE1F0, `done_o` one cycle after the 8th bit, `pass_o`=1, `bit_cnt_o`=8.
- `CHAIN_LEN`=72, ASCII "123456789" MSB-first with random gaps in `shift_en_i`, golden 16'h29B1 -> `pass_o`=1; the same stream with one bit flipped -> `fail_o`=1.
- Golden 16'h0000 with the 8-zero-bit stream -> `fail_o`=1, `pass_o`=0.
- `start_i` after 5 of 8 bits, then 8 zero bits -> restart; `bit_cnt_o`=8, `crc_o`=16'hE1F0, pass.
- `rst_ni` low for one cycle mid-RUN -> IDLE, all outputs at reset values; a subsequent `sig_shift_i` reloads golden correctly.
- With `CCFF_MON_OVERRUN_EN`: a 9th shift after DONE, then start and a correct 8-bit run -> `pass_o`=1, because the flag is cleared by start. A 9th shift in the CHECK cycle -> `fail_o`=1 despite a matching CRC.
